// File: rtl/fir_stream_pkg.sv
// Shared types for the FIR stream return path: default sample width, beat record
// and packet-tracker states.
package fir_stream_pkg;

   localparam int DEF_DATA_W = 32;

   typedef struct packed {
      logic [DEF_DATA_W-1:0] data;
      logic                  sop;
      logic                  eop;
   } fir_beat_t;

   typedef enum logic {
      IDLE   = 1'b0,
      IN_PKT = 1'b1
   } pkt_state_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO. The head entry is always visible on dout, and
// pointers wrap explicitly so that non-power-of-two depths work.
module sync_fifo_fwft #(
   parameter  int WIDTH = 34,
   parameter  int DEPTH = 8,
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   logic [DEPTH-1:0][WIDTH-1:0] mem;
   logic [PW-1:0]               wr_ptr;
   logic [PW-1:0]               rd_ptr;
   logic                        wr_en;
   logic                        rd_en;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign rd_en = pop & ~empty;
   // A full FIFO still takes a write when the head leaves in the same cycle.
   assign wr_en = push & (~full | rd_en);
   assign dout  = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ptr_inc(wr_ptr);
         end
         if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
         count <= count + CW'(wr_en) - CW'(rd_en);
      end
   end

endmodule

// File: rtl/fir_source_credit_buffer.sv
// Credit-based return buffer behind the non-stallable FIR pipeline. Upstream ready
// is withheld once every FIFO slot is reserved by a buffered or in-flight beat.
module fir_source_credit_buffer
   import fir_stream_pkg::*;
#(
   parameter  int DATA_W       = DEF_DATA_W,
   parameter  int PIPE_LATENCY = 5,
   parameter  int DEPTH        = 8,
   localparam int CW           = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sink_valid,
   output logic              sink_ready,
   input  logic              pipe_valid,
   input  logic [DATA_W-1:0] pipe_data,
   input  logic              pipe_sop,
   input  logic              pipe_eop,
   output logic              src_valid,
   input  logic              src_ready,
   output logic [DATA_W-1:0] src_data,
   output logic              src_sop,
   output logic              src_eop,
   output logic [CW-1:0]     fill_level,
   output logic              overflow_err,
   output logic              framing_err
);

   if (DEPTH < 2) begin : g_depth_err
      $error("fir_source_credit_buffer: DEPTH must be at least 2");
   end
   if (DEPTH < PIPE_LATENCY + 2) begin : g_depth_warn
      $warning("fir_source_credit_buffer: DEPTH below PIPE_LATENCY+2 limits throughput");
   end

   logic              ready_en;
   logic [CW-1:0]     reserved;
   logic              acc;
   logic              pop;
   logic              full;
   logic              empty;
   logic              frame_bad;
   logic [DATA_W+1:0] head;
   pkt_state_t        state;
   pkt_state_t        state_nxt;

   // Registers only: ready has zero latency, so no combinational path from sink_valid.
   assign sink_ready = ready_en & (reserved < CW'(DEPTH));
   assign acc        = sink_valid & sink_ready;
   assign src_valid  = ~empty;
   assign pop        = src_valid & src_ready;

   sync_fifo_fwft #(
      .WIDTH (DATA_W + 2),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (pipe_valid),
      .pop   (pop),
      .din   ({pipe_data, pipe_sop, pipe_eop}),
      .dout  (head),
      .count (fill_level),
      .full  (full),
      .empty (empty)
   );

   assign {src_data, src_sop, src_eop} = head;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ready_en <= 1'b0;
      else     ready_en <= 1'b1;
   end

   // Saturating in both directions so a misbehaving pipeline cannot wrap the count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         reserved <= '0;
      else if (acc && !pop && reserved != CW'(DEPTH))
         reserved <= reserved + 1'b1;
      else if (pop && !acc && reserved != '0)
         reserved <= reserved - 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_err <= 1'b0;
         framing_err  <= 1'b0;
      end else begin
         overflow_err <= overflow_err | (pipe_valid & full & ~pop);
         framing_err  <= framing_err | frame_bad;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // A stray sop inside a packet restarts it; the beat itself is never blocked.
   always_comb begin
      state_nxt = state;
      frame_bad = 1'b0;
      if (pipe_valid) begin
         case (state)
            IDLE: begin
               if (!pipe_sop)      frame_bad = 1'b1;
               else if (!pipe_eop) state_nxt = IN_PKT;
            end
            IN_PKT: begin
               frame_bad = pipe_sop;
               if (pipe_eop) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

endmodule

// File: doc/fir_source_credit_buffer.md
Name: fir_source_credit_buffer

Overview:
- Return-path companion to the FIR stream's fixed-latency sideband delay line.
- Receives beats leaving the non-stallable FIR pipeline and buffers them in a small FIFO.
- Drives the Avalon-ST source toward the downstream consumer.
- Generates the upstream Avalon-ST sink ready from a credit count, so beats already in flight in the pipeline always have a reserved FIFO slot. Downstream backpressure is thereby propagated upstream without stalling the filter.

Parameters:
- DATA_W, 32: sample width in bits.
- PIPE_LATENCY, 5: cycles from upstream accept to pipe_valid. Used for the elaboration check only.
- DEPTH, 8: FIFO entries. Elaboration error if DEPTH < 2. DEPTH >= PIPE_LATENCY+2 is required for full throughput.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- sink_valid  in  1  upstream valid, monitored to count accepted beats.
- sink_ready  out  1  upstream ready, ready latency 0.
- pipe_valid  in  1  beat emerging from the FIR pipeline.
- pipe_data  in  DATA_W  filtered sample.
- pipe_sop  in  1  start of packet.
- pipe_eop  in  1  end of packet.
- src_valid  out  1  source valid.
- src_ready  in  1  downstream ready.
- src_data  out  DATA_W  head-of-FIFO data.
- src_sop  out  1  head-of-FIFO start of packet.
- src_eop  out  1  head-of-FIFO end of packet.
- fill_level  out  $clog2(DEPTH+1)  current FIFO occupancy.
- overflow_err  out  1  sticky: a pipe beat arrived with no free slot.
- framing_err  out  1  sticky: sop/eop protocol violation on the pipe side.

Behaviour:
- Reset values: every output is 0. The FIFO, credit counter, packet state and error flags are cleared.
- Reset is asynchronous and takes effect immediately, even mid-packet. Buffered and in-flight beats are discarded.
- ready_en flop:
  - Cleared by reset; set on the first clk edge after rst deasserts.
  - sink_ready = ready_en & (reserved < DEPTH). It is a function of registers only.
- Credit counter "reserved" (width $clog2(DEPTH+1)):
  - acc = sink_valid & sink_ready; pop = src_valid & src_ready.
  - reserved_nxt = reserved + acc - pop.
  - Simultaneous acc and pop leave the count unchanged.
  - The counter never exceeds DEPTH and never wraps.
- FIFO (first-word-fall-through, DEPTH entries, each entry = {data, sop, eop}):
  - push = pipe_valid. src_valid = (fill_level != 0).
  - src_data, src_sop and src_eop are the head entry and are held stable while src_valid & !src_ready.
  - Latency: pipe_valid at edge N gives src_valid high after edge N+1, i.e. one cycle, including when the FIFO was empty.
  - Full with push and no pop: the beat is dropped, overflow_err is set and fill_level stays DEPTH.
  - Full with push and pop in the same cycle: both are accepted and fill_level stays DEPTH.
  - Empty: no pop is possible. A push alone moves fill_level 0 -> 1.
  - Pointers are log2-wrapped. Non-power-of-two DEPTH wraps explicitly at DEPTH-1 -> 0.
- Packet tracker, states IDLE and IN_PKT, evaluated on pipe_valid beats:
  - IDLE + sop & eop -> IDLE (single-beat packet).
  - IDLE + sop & !eop -> IN_PKT.
  - IDLE + !sop -> framing_err set; the beat is still pushed.
  - IN_PKT + eop -> IDLE.
  - IN_PKT + sop -> framing_err set; the tracker restarts the packet (stays IN_PKT, or goes to IDLE if eop is also set).
- Error flags: overflow_err and framing_err clear only on rst.
- Credit invariant: reserved = fill_level + beats in flight. A correct pipeline therefore never triggers overflow_err.

Decomposition:
- Package fir_stream_pkg holds:
  - DATA_W default constant.
  - typedef struct packed fir_beat_t {data, sop, eop}.
  - typedef enum pkt_state_t {IDLE, IN_PKT}.
- One sub-module: sync_fifo_fwft (parameters WIDTH, DEPTH; ports push, pop, din, dout, count, full, empty).
- Credit counter, ready_en and packet tracker remain in the top module.

Test Plan:
- Reset release: rst 1->0 with sink_valid=1 -> sink_ready=0 in the first cycle, 1 in the next; all other outputs 0 throughout.
- Streaming, defaults, src_ready=1, 20 back-to-back accepts with pipe_valid echoed 5 cycles later:
  - sink_ready stays 1 throughout.
  - src beats match in order, each 1 cycle after its pipe_valid.
  - fill_level <= 1; no errors.
- Backpressure: src_ready=0 while streaming:
  - sink_ready falls once reserved reaches 8.
  - Exactly 8 beats are stored, fill_level=8, overflow_err=0.
  - Releasing src_ready drains 8 beats in order; sink_ready returns 1 cycle after the first pop.
- Overflow and full-boundary:
  - Force pipe_valid with FIFO full and src_ready=0 -> overflow_err=1, beat dropped, fill_level=8.
  - Same with src_ready=1 -> no error, fill_level stays 8.
- Framing:
  - Beats sop,-,eop -> no error.
  - A beat without sop in IDLE -> framing_err=1.
  - sop while IN_PKT -> framing_err=1.
  - In both error cases the beats still appear on src.
- Mid-operation reset: assert rst with fill_level=5, reserved=7 -> immediately src_valid=0, fill_level=0, errors 0; after release, a fresh stream of 10 beats passes cleanly.
